// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage and the decode control unit:
// next-PC select encodings, fetch FSM state encodings and PC helpers.
package instruction_fetch_pkg;

   typedef enum logic [1:0] {
      PCSRC_PC4 = 2'b00,
      PCSRC_BR  = 2'b01,
      PCSRC_JR  = 2'b10,
      PCSRC_J   = 2'b11
   } pcsrc_e;

   typedef enum logic [1:0] {
      FETCH   = 2'b00,
      HOLD    = 2'b01,
      DISCARD = 2'b10
   } if_state_e;

   localparam logic [31:0] PC_STEP = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_ifid.sv
// IF/ID pipeline register: flush inserts a bubble (pc4 kept), load captures
// a new instruction, otherwise the register holds.
module ifid_reg #(
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] load_inst,
   input  logic [31:0] load_pc4,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc4,
   output logic        if_valid
);

   // Register update; flush wins over load.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_inst  <= NOP_INST;
         if_pc4   <= 32'd0;
         if_valid <= 1'b0;
      end else if (flush) begin
         if_inst  <= NOP_INST;
         if_valid <= 1'b0;
      end else if (load) begin
         if_inst  <= load_inst;
         if_pc4   <= load_pc4;
         if_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, next-PC select, fetch FSM with a
// one-entry skid buffer for decode stalls and a pending-target register for
// redirects that arrive while a fetch is outstanding.
// Optional build macro IFETCH_PERF_CNT_EN adds fetch/stall perf counters.
//
// state   | meaning
// FETCH   | request outstanding at pc
// HOLD    | fetched word parked in skid, waiting for decode stall to clear
// DISCARD | redirect taken, waiting to drop the stale response at old pc
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_en,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] jpc,
   input  logic [31:0] jr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc4,
   output logic [31:0] if_inst,
   output logic        if_valid
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   if_state_e   state, state_nxt;
   logic [31:0] pc, pc_nxt, pc_plus4;
   logic [31:0] pend, pend_nxt;
   logic [31:0] skid_inst, skid_inst_nxt;
   logic [31:0] skid_pc4, skid_pc4_nxt;
   logic [31:0] target;
   logic [31:0] ld_inst, ld_pc4;
   logic        redirect, ifid_load, ifid_flush;

   assign pc_plus4  = pc + PC_STEP;
   assign redirect  = !stall_en && (pcsource != PCSRC_PC4);
   assign imem_req  = !rst && (state != HOLD);
   assign imem_addr = word_align(pc);

   // Redirect target select; low bits cleared so pc stays word aligned.
   always_comb begin
      target = word_align(pc_plus4);
      case (pcsource)
         PCSRC_BR: target = word_align(bpc);
         PCSRC_JR: target = word_align(jr_target);
         PCSRC_J:  target = word_align(jpc);
         default:  target = word_align(pc_plus4);
      endcase
   end

   // Next-state, next-PC and IF/ID control.
   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      pend_nxt      = pend;
      skid_inst_nxt = skid_inst;
      skid_pc4_nxt  = skid_pc4;
      ifid_load     = 1'b0;
      ifid_flush    = 1'b0;
      ld_inst       = imem_rdata;
      ld_pc4        = pc_plus4;
      case (state)
         FETCH: begin
            if (redirect) begin
               ifid_flush = 1'b1;
               if (imem_ready) begin
                  pc_nxt = target;
               end else begin
                  pend_nxt  = target;
                  state_nxt = DISCARD;
               end
            end else if (imem_ready) begin
               if (stall_en) begin
                  skid_inst_nxt = imem_rdata;
                  skid_pc4_nxt  = pc_plus4;
                  state_nxt     = HOLD;
               end else begin
                  ifid_load = 1'b1;
                  pc_nxt    = pc_plus4;
               end
            end else if (!stall_en) begin
               ifid_flush = 1'b1;
            end
         end
         HOLD: begin
            if (redirect) begin
               ifid_flush = 1'b1;
               pc_nxt     = target;
               state_nxt  = FETCH;
            end else if (!stall_en) begin
               ifid_load = 1'b1;
               ld_inst   = skid_inst;
               ld_pc4    = skid_pc4;
               pc_nxt    = pc_plus4;
               state_nxt = FETCH;
            end
         end
         DISCARD: begin
            // A newer redirect replaces the pending target; the stale
            // response is still dropped.
            if (redirect) begin
               ifid_flush = 1'b1;
               if (imem_ready) begin
                  pc_nxt    = target;
                  state_nxt = FETCH;
               end else begin
                  pend_nxt = target;
               end
            end else if (imem_ready) begin
               pc_nxt    = pend;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   // State, PC, skid and pending registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         pend      <= 32'd0;
         skid_inst <= 32'd0;
         skid_pc4  <= 32'd0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         pend      <= pend_nxt;
         skid_inst <= skid_inst_nxt;
         skid_pc4  <= skid_pc4_nxt;
      end
   end

   ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
      .clk       (clk),
      .rst       (rst),
      .load      (ifid_load),
      .flush     (ifid_flush),
      .load_inst (ld_inst),
      .load_pc4  (ld_pc4),
      .if_inst   (if_inst),
      .if_pc4    (if_pc4),
      .if_valid  (if_valid)
   );

`ifdef IFETCH_PERF_CNT_EN
   logic fetch_acc;

   // A fetch counts once, when its data is accepted and not being dropped.
   assign fetch_acc = (state == FETCH) && imem_ready && !redirect;

   // Performance counters, free-running and wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt <= 32'd0;
         perf_stall_cnt <= 32'd0;
      end else begin
         if (fetch_acc)
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (stall_en || (state == HOLD))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`else
   // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch. The reference model
// tracks the next fetch address, outstanding-discard and skid occupancy;
// accepted fetches are queued and popped by the monitor on delivery.
module tb_instruction_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_en = 1'b0;
   logic [1:0]  pcsource = 2'b00;
   logic [31:0] bpc = '0, jpc = '0, jr_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] if_pc4, if_inst;
   logic        if_valid;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

   instruction_fetch #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall_en   (stall_en),
      .pcsource   (pcsource),
      .bpc        (bpc),
      .jpc        (jpc),
      .jr_target  (jr_target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .if_pc4     (if_pc4),
      .if_inst    (if_inst),
      .if_valid   (if_valid)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc4;
      logic [31:0] inst;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_addr = RST_PC;
   logic [31:0] m_pend = '0;
   bit          m_skid = 1'b0;
   bit          m_disc = 1'b0;
   bit          m_rst_seen = 1'b1;
   logic [31:0] m_fetch_cnt = '0;
   logic [31:0] m_stall_cnt = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: check current outputs against the model, drive
   // inputs for the coming edge, then advance the model across that edge.
   task automatic cycle(input bit r, input bit st, input logic [1:0] ps,
                        input logic [31:0] b, input logic [31:0] j,
                        input logic [31:0] jr, input bit rdy);
      bit          redir;
      logic [31:0] tgt;
      @(negedge clk);
      if (rst) check("req_in_reset", {31'd0, imem_req}, 32'd0);
      if (m_rst_seen) begin
         check("rst_addr", imem_addr, RST_PC);
         check("rst_valid", {31'd0, if_valid}, 32'd0);
         check("rst_inst", if_inst, NOP);
         check("rst_pc4", if_pc4, 32'd0);
      end else if (!rst) begin
         check("imem_req", {31'd0, imem_req}, {31'd0, !m_skid});
         if (!m_skid) check("imem_addr", imem_addr, m_addr);
      end
`ifdef IFETCH_PERF_CNT_EN
      check("perf_fetch", perf_fetch_cnt, m_fetch_cnt);
      check("perf_stall", perf_stall_cnt, m_stall_cnt);
`endif
      rst        = r;
      stall_en   = st;
      pcsource   = ps;
      bpc        = b;
      jpc        = j;
      jr_target  = jr;
      imem_ready = rdy;
      imem_rdata = rdy ? mem_word(imem_addr) : $urandom;

      if (r) begin
         exp_q.delete();
         m_addr = RST_PC; m_pend = '0; m_skid = 0; m_disc = 0;
         m_fetch_cnt = '0; m_stall_cnt = '0;
         m_rst_seen = 1;
      end else begin
         m_rst_seen = 0;
         redir = !st && (ps != 2'b00);
         tgt = (ps == 2'b01) ? b : (ps == 2'b10) ? jr : j;
         tgt = tgt & 32'hFFFF_FFFC;
         if (st || m_skid) m_stall_cnt = m_stall_cnt + 1;
         if (m_skid) begin
            if (redir) begin
               exp_q.delete(); m_skid = 0; m_addr = tgt;
            end else if (!st) begin
               m_skid = 0; m_addr = m_addr + 4;
            end
         end else if (redir) begin
            if (rdy) begin m_addr = tgt; m_disc = 0; end
            else begin m_disc = 1; m_pend = tgt; end
         end else if (rdy) begin
            if (m_disc) begin
               m_disc = 0; m_addr = m_pend;
            end else begin
               exp_q.push_back('{pc4: m_addr + 4, inst: mem_word(m_addr)});
               m_fetch_cnt = m_fetch_cnt + 1;
               if (st) m_skid = 1;
               else m_addr = m_addr + 4;
            end
         end
      end
   endtask

   // Monitor: after each unstalled edge a valid IF/ID is a new delivery.
   logic [31:0] prev_inst;
   logic        prev_valid;
   always begin
      bit   st_s, r_s;
      exp_t e;
      @(posedge clk);
      st_s = stall_en;
      r_s  = rst;
      #1;
      if (!r_s) begin
         if (!st_s) begin
            if (if_valid) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL delivery actual=inst %h expected=nothing queued t=%0t", if_inst, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("deliver_inst", if_inst, e.inst);
                  check("deliver_pc4", if_pc4, e.pc4);
               end
            end else begin
               check("bubble_inst", if_inst, NOP);
            end
            check("queue_drained", 32'(exp_q.size()), 32'd0);
         end else begin
            check("hold_inst", if_inst, prev_inst);
            check("hold_valid", {31'd0, if_valid}, {31'd0, prev_valid});
         end
      end
      prev_inst  = if_inst;
      prev_valid = if_valid;
   end

   function automatic logic [31:0] pick_tgt();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         default: return 32'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      cycle(1, 0, 2'b00, 0, 0, 0, 0);
      cycle(1, 0, 2'b00, 0, 0, 0, 1);
`ifdef IFETCH_PERF_CNT_EN
      for (int i = 0; i < 5; i++) cycle(0, 0, 2'b00, 0, 0, 0, 1);
      cycle(0, 1, 2'b00, 0, 0, 0, 0);
      cycle(0, 1, 2'b00, 0, 0, 0, 0);
      cycle(0, 0, 2'b00, 0, 0, 0, 0);
      check("perf_fetch_5", perf_fetch_cnt, 32'd5);
      check("perf_stall_2", perf_stall_cnt, 32'd2);
      cycle(1, 0, 2'b00, 0, 0, 0, 0);
`endif
      // sequential fetch from reset
      for (int i = 0; i < 3; i++) cycle(0, 0, 2'b00, 0, 0, 0, 1);
      // stall while a fetch completes, then release
      cycle(0, 1, 2'b00, 0, 0, 0, 1);
      cycle(0, 1, 2'b01, 32'h200, 0, 0, 1);
      cycle(0, 1, 2'b00, 0, 0, 0, 0);
      cycle(0, 0, 2'b00, 0, 0, 0, 0);
      // branch with ready
      cycle(0, 0, 2'b01, 32'h100, 0, 0, 1);
      cycle(0, 0, 2'b00, 0, 0, 0, 1);
      // jump while memory is slow
      cycle(0, 0, 2'b11, 0, 32'h40, 0, 0);
      cycle(0, 0, 2'b00, 0, 0, 0, 0);
      cycle(0, 0, 2'b00, 0, 0, 0, 1);
      cycle(0, 0, 2'b00, 0, 0, 0, 1);
      // misaligned jr near the top of memory, then wrap
      cycle(0, 0, 2'b10, 0, 0, 32'hFFFF_FFFA, 1);
      cycle(0, 0, 2'b00, 0, 0, 0, 1);
      cycle(0, 0, 2'b00, 0, 0, 0, 1);
      cycle(0, 0, 2'b00, 0, 0, 0, 1);
      // reset in the middle of a discard
      cycle(0, 0, 2'b11, 0, 32'h80, 0, 0);
      cycle(1, 0, 2'b00, 0, 0, 0, 1);
      cycle(0, 0, 2'b00, 0, 0, 0, 1);
      cycle(0, 0, 2'b00, 0, 0, 0, 1);
      // random traffic
      for (int i = 0; i < 4000; i++) begin
         bit          r, st, rdy;
         logic [1:0]  ps;
         r   = ($urandom_range(0, 199) == 0);
         st  = ($urandom_range(0, 3) == 0);
         ps  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rdy = ($urandom_range(0, 2) != 0);
         cycle(r, st, ps, pick_tgt(), pick_tgt(), pick_tgt(), rdy);
      end
      cycle(0, 0, 2'b00, 0, 0, 0, 0);
      cycle(0, 0, 2'b00, 0, 0, 0, 0);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0000, bubble word written to if_inst on flush.
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_en  in  1  decode-stage hazard stall; holds PC and the IF/ID register.
- pcsource  in  2  next-PC select from decode: 00 pc+4, 01 bpc, 10 jr_target, 11 jpc.
- bpc  in  32  branch target.
- jpc  in  32  jump target.
- jr_target  in  32  register-indirect target (decode operand a).
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ready  in  1  response valid; imem_rdata sampled this cycle.
- imem_rdata  in  32  fetched instruction.
- if_pc4  out  32  registered PC+4 of the instruction in IF/ID; feeds decode pc4.
- if_inst  out  32  registered instruction; feeds decode inst.
- if_valid  out  1  IF/ID holds a real instruction.

Function
REQ-004 SHALL hold a 32-bit pc register; imem_addr equals pc, with bits [1:0] forced to 00.
REQ-005 SHALL implement FSM {FETCH, HOLD, DISCARD}; reset state FETCH.
REQ-006 FETCH: imem_req=1; imem_addr stable until imem_ready.
REQ-007 FETCH, imem_ready=1, stall_en=0, pcsource=00: if_inst<=imem_rdata, if_pc4<=pc+4, if_valid<=1, pc<=pc+4; stay FETCH.
REQ-008 FETCH, imem_ready=1, stall_en=1: capture imem_rdata and pc+4 in skid register; keep IF/ID and pc; go HOLD.
REQ-009 HOLD: imem_req=0; when stall_en falls to 0, load IF/ID from skid, pc<=pc+4; go FETCH.
REQ-010 Redirect = stall_en=0 and pcsource!=00; SHALL be ignored while stall_en=1.
REQ-011 Redirect: if_inst<=NOP_INST, if_valid<=0, if_pc4 unchanged; target selected per pcsource.
REQ-012 Redirect in FETCH with imem_ready=1: discard imem_rdata, pc<=target; stay FETCH.
REQ-013 Redirect in FETCH with imem_ready=0: latch target in pending register; go DISCARD; imem_req and imem_addr held.
REQ-014 DISCARD: imem_req=1 at old address; on imem_ready, drop data, pc<=pending target, go FETCH.
REQ-015 Redirect in HOLD: drop skid contents, pc<=target; go FETCH.
REQ-016 FETCH with imem_ready=0 and no redirect: IF/ID and pc unchanged. if_valid unchanged unless stall_en=0, in which case if_valid<=0 and if_inst<=NOP_INST (bubble).
REQ-017 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-018 Misaligned targets SHALL have bits [1:0] cleared on load into pc.

Reset
REQ-019 While rst=1: pc=RESET_PC, if_inst=NOP_INST, if_pc4=0, if_valid=0, imem_req=0, skid and pending registers cleared, state FETCH.
REQ-020 rst asserted mid-transaction SHALL abandon any outstanding fetch; imem_ready during rst SHALL be ignored.

Configuration
REQ-021 Macro IFETCH_PERF_CNT_EN SHALL add outputs perf_fetch_cnt[31:0] (accepted, non-discarded fetches) and perf_stall_cnt[31:0] (cycles with stall_en=1 or state HOLD).
REQ-022 Both counters SHALL reset to 0 and wrap modulo 2^32.
REQ-023 Without the macro, neither the counter ports nor the counter logic SHALL exist.

Structure
REQ-024 Shared package SHALL hold the pcsource encodings (PCSRC_PC4, PCSRC_BR, PCSRC_JR, PCSRC_J) and the FSM state encodings, for use by the decode control unit.
REQ-025 One sub-module, ifid_reg, SHALL implement the IF/ID register with load, flush and hold controls; the next-PC mux and FSM stay in the top module.

Verification
REQ-026 rst 1 cycle, then imem_ready=1 each cycle, rdata=0x11,0x22 -> imem_addr 0,4,8; if_inst 0x11 with if_pc4=4, then 0x22 with if_pc4=8.
REQ-027 stall_en=1 for 3 cycles while a fetch completes -> if_inst and pc frozen, imem_req=0 in HOLD; skid instruction appears the cycle after stall_en falls.
REQ-028 pcsource=01, bpc=0x100, imem_ready=1 -> if_valid=0, if_inst=NOP_INST; next imem_addr=0x100.
REQ-029 pcsource=11, jpc=0x40 while imem_ready=0 for 2 cycles -> imem_addr held; returned data dropped; next imem_addr=0x40.
REQ-030 pc=0xFFFF_FFFC, sequential fetch -> next imem_addr=0x0; rst mid-DISCARD -> imem_addr=RESET_PC, if_valid=0.
REQ-031 With IFETCH_PERF_CNT_EN: 5 fetches and a 2-cycle stall -> perf_fetch_cnt=5, perf_stall_cnt=2.
